// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: unpacked float, divider states.
package fpu_pkg;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MIN  = -10'sd126;
    localparam logic signed [9:0] EXP_MAX  = 10'sd127;
    localparam logic [31:0]       QNAN     = 32'hFFC00000;

    typedef enum logic [3:0] {
        IDLE,
        SPECIAL,
        NORMALISE,
        DIVIDE_0,
        DIVIDE_1,
        DIVIDE_2,
        NORMALISE_1,
        NORMALISE_2,
        ROUND,
        PACK,
        PUT_Z
    } div_state_t;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE single into sign, unbiased exponent and mantissa plus class bits.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]  word,
    output fp_unpacked_t u,
    output logic         is_nan,
    output logic         is_inf,
    output logic         is_zero,
    output logic         is_snan
);

    logic [7:0]  e_f;
    logic [22:0] f;

    assign e_f = word[30:23];
    assign f   = word[22:0];

    assign u.sign = word[31];
    assign u.exp  = {2'b00, e_f} - EXP_BIAS;
    assign u.mant = {1'b0, f};

    assign is_nan  = (&e_f) && (|f);
    assign is_inf  = (&e_f) && !(|f);
    assign is_zero = !(|e_f) && !(|f);
    assign is_snan = is_nan && !f[22];

endmodule

// File: rtl/fdivider.sv
// IEEE-754 single divider, restoring, one quotient bit per clock, RNE.
// Define FDIVIDER_FLAGS_EN to add the output_flags {NV,DZ,OF,UF,NX} port.
module fdivider
    import fpu_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] output_z,
    output logic        output_z_stb
`ifdef FDIVIDER_FLAGS_EN
    ,
    output logic [4:0]  output_flags
`endif
);

    div_state_t state, state_nxt;

    fp_unpacked_t ua, ub;
    logic ua_nan, ua_inf, ua_zero, ua_snan;
    logic ub_nan, ub_inf, ub_zero, ub_snan;

    logic              a_s, b_s, z_s;
    logic signed [9:0] a_e, b_e, z_e;
    logic [23:0]       a_m, b_m, z_m;
    logic              a_nan, a_inf, a_zero;
    logic              b_nan, b_inf, b_zero;
    logic [50:0]       q, dvd;
    logic [24:0]       r, r_sh;
    logic              r_ge;
    logic [CNT_W-1:0]  cnt;
    logic              guard, round_b, sticky;
    logic [31:0]       z, sp_z;
    logic              sp_s, sp_nv, is_special, rnd_up, ovf, tiny;
    logic [7:0]        pk_exp;

    fp_unpack u_unpack_a (
        .word    (input_a),
        .u       (ua),
        .is_nan  (ua_nan),
        .is_inf  (ua_inf),
        .is_zero (ua_zero),
        .is_snan (ua_snan)
    );

    fp_unpack u_unpack_b (
        .word    (input_b),
        .u       (ub),
        .is_nan  (ub_nan),
        .is_inf  (ub_inf),
        .is_zero (ub_zero),
        .is_snan (ub_snan)
    );

    assign sp_s       = a_s ^ b_s;
    assign sp_nv      = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    always_comb begin
        sp_z = {sp_s, 8'h00, 23'd0};
        if (sp_nv)       sp_z = QNAN;
        else if (a_inf)  sp_z = {sp_s, 8'hFF, 23'd0};
        else if (b_inf)  sp_z = {sp_s, 8'h00, 23'd0};
        else if (b_zero) sp_z = {sp_s, 8'hFF, 23'd0};
    end

    assign r_sh   = {r[23:0], dvd[50]};
    assign r_ge   = r_sh >= {1'b0, b_m};
    assign rnd_up = guard && (round_b || sticky || z_m[0]);
    assign ovf    = z_e > EXP_MAX;
    assign tiny   = (z_e == EXP_MIN) && !z_m[23];
    assign pk_exp = 8'(z_e + EXP_BIAS);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SPECIAL;
            end
            SPECIAL:     state_nxt = is_special ? PUT_Z : NORMALISE;
            NORMALISE:   if (a_m[23] && b_m[23]) state_nxt = DIVIDE_0;
            DIVIDE_0:    state_nxt = DIVIDE_1;
            DIVIDE_1:    if (cnt == CNT_W'(50)) state_nxt = DIVIDE_2;
            DIVIDE_2:    state_nxt = NORMALISE_1;
            NORMALISE_1: if (z_m[23]) state_nxt = NORMALISE_2;
            NORMALISE_2: if (!(z_e < EXP_MIN)) state_nxt = ROUND;
            ROUND:       state_nxt = PACK;
            PACK:        state_nxt = PUT_Z;
            PUT_Z:       state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_z     <= '0;
            output_z_stb <= 1'b0;
        end else begin
            output_z_stb <= 1'b0;
            unique case (state)
                IDLE: if (in_valid) begin
                    a_s <= ua.sign; a_e <= ua.exp; a_m <= ua.mant;
                    b_s <= ub.sign; b_e <= ub.exp; b_m <= ub.mant;
                    a_nan <= ua_nan; a_inf <= ua_inf; a_zero <= ua_zero;
                    b_nan <= ub_nan; b_inf <= ub_inf; b_zero <= ub_zero;
                end
                SPECIAL: begin
                    z <= sp_z;
                    if (a_e == EXP_MIN - 10'sd1) a_e <= EXP_MIN;
                    else                         a_m[23] <= 1'b1;
                    if (b_e == EXP_MIN - 10'sd1) b_e <= EXP_MIN;
                    else                         b_m[23] <= 1'b1;
                end
                NORMALISE: begin
                    if (!a_m[23]) begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 10'sd1;
                    end
                    if (!b_m[23]) begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 10'sd1;
                    end
                end
                DIVIDE_0: begin
                    z_s <= a_s ^ b_s;
                    z_e <= a_e - b_e;
                    // The first 23 dividend bits always give zero quotient
                    // bits (R < b_m), so they are preloaded into R.
                    r   <= {2'b00, a_m[23:1]};
                    dvd <= {a_m[0], 50'd0};
                    q   <= '0;
                    cnt <= '0;
                end
                DIVIDE_1: begin
                    dvd <= dvd << 1;
                    q   <= {q[49:0], r_ge};
                    r   <= r_ge ? r_sh - {1'b0, b_m} : r_sh;
                    cnt <= cnt + CNT_W'(1);
                end
                DIVIDE_2: begin
                    z_m     <= q[50:27];
                    guard   <= q[26];
                    round_b <= q[25];
                    sticky  <= (|q[24:0]) | (|r);
                end
                NORMALISE_1: if (!z_m[23]) begin
                    z_m     <= {z_m[22:0], guard};
                    z_e     <= z_e - 10'sd1;
                    guard   <= round_b;
                    round_b <= 1'b0;
                end
                NORMALISE_2: if (z_e < EXP_MIN) begin
                    z_e     <= z_e + 10'sd1;
                    z_m     <= z_m >> 1;
                    guard   <= z_m[0];
                    round_b <= guard;
                    sticky  <= sticky | round_b;
                end
                ROUND: if (rnd_up) begin
                    if (z_m == 24'hFFFFFF) begin
                        z_e <= z_e + 10'sd1;
                        z_m <= 24'h800000;
                    end else begin
                        z_m <= z_m + 24'd1;
                    end
                end
                PACK: begin
                    if (ovf)       z <= {z_s, 8'hFF, 23'd0};
                    else if (tiny) z <= {z_s, 8'h00, z_m[22:0]};
                    else           z <= {z_s, pk_exp, z_m[22:0]};
                end
                PUT_Z: begin
                    output_z     <= z;
                    output_z_stb <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FDIVIDER_FLAGS_EN
    logic a_snan, b_snan, inexact;
    logic f_nv, f_dz, f_of, f_uf, f_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            output_flags <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_snan <= ua_snan;
                b_snan <= ub_snan;
            end
            if (state == SPECIAL) begin
                f_nv <= (a_zero & b_zero) | (a_inf & b_inf) | a_snan | b_snan;
                f_dz <= b_zero & !a_nan & !a_inf & !a_zero;
                f_of <= 1'b0;
                f_uf <= 1'b0;
                f_nx <= 1'b0;
            end
            if (state == ROUND) inexact <= guard | round_b | sticky;
            if (state == PACK) begin
                f_of <= ovf;
                f_uf <= tiny & inexact;
                f_nx <= inexact | ovf;
            end
            if (state == PUT_Z) output_flags <= {f_nv, f_dz, f_of, f_uf, f_nx};
        end
    end
`else
    logic unused_snan;
    assign unused_snan = ua_snan ^ ub_snan;
`endif

endmodule

// File: tb/tb_fdivider.sv
// Directed vector bench for fdivider: results, latency, flags and mid-divide reset.
module tb_fdivider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_z;
    logic        output_z_stb;
`ifdef FDIVIDER_FLAGS_EN
    logic [4:0]  output_flags;
`endif

    fdivider #(.CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_b      (input_b),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .output_z     (output_z),
        .output_z_stb (output_z_stb)
`ifdef FDIVIDER_FLAGS_EN
        ,
        .output_flags (output_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Latency counts clock edges from the transfer edge (1) to the strobe edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] z, output logic [4:0] fl,
                          output int cyc);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (output_z_stb !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        z = output_z;
`ifdef FDIVIDER_FLAGS_EN
        fl = output_flags;
`else
        fl = 5'd0;
`endif
        @(posedge clk);
        #1;
        check("stb_one_cycle", {31'd0, output_z_stb}, 32'd0);
    endtask

    logic [31:0] z;
    logic [4:0]  fl;
    int          cyc;
    int          strobes;

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 61};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 62};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 3};
        vecs[3]  = '{32'h00000000, 32'h80000000, 32'hFFC00000, 5'b10000, 3};
        vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 61};
        vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00400000, 5'b00000, 62};
        vecs[6]  = '{32'h00000001, 32'h3F000000, 32'h00000002, 5'b00000, 106};
        vecs[7]  = '{32'h00000001, 32'h40000000, 32'h00000000, 5'b00011, 108};
        vecs[8]  = '{32'h00000003, 32'h40000000, 32'h00000002, 5'b00011, 106};
        vecs[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 61};
        vecs[10] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 5'b10000, 3};
        vecs[11] = '{32'h7FA00000, 32'h3F800000, 32'hFFC00000, 5'b10000, 3};
        vecs[12] = '{32'h7FC00000, 32'h3F800000, 32'hFFC00000, 5'b00000, 3};
        vecs[13] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 3};
        vecs[14] = '{32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 3};
        vecs[15] = '{32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 3};
        vecs[16] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 61};

        rst      = 1'b1;
        in_valid = 1'b0;
        input_a  = '0;
        input_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_z", output_z, 32'd0);
        check("rst_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef FDIVIDER_FLAGS_EN
        check("rst_flags", {27'd0, output_flags}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, z, fl, cyc);
            check($sformatf("z[%0d]", i), z, vecs[i].z);
            check($sformatf("lat[%0d]", i), cyc, vecs[i].lat);
`ifdef FDIVIDER_FLAGS_EN
            check($sformatf("flags[%0d]", i), {27'd0, fl}, {27'd0, vecs[i].fl});
`endif
        end

        // Reset 20 cycles into a divide: operation is dropped silently.
        @(negedge clk);
        input_a  = 32'h40C00000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("busy_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_stb", {31'd0, output_z_stb}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_z", output_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (output_z_stb) strobes++;
        end
        check("midrst_no_strobe", strobes, 32'd0);

        run_op(32'h40C00000, 32'h40000000, z, fl, cyc);
        check("post_rst_z", z, 32'h40400000);
        check("post_rst_lat", cyc, 32'd61);
`ifdef FDIVIDER_FLAGS_EN
        check("post_rst_flags", {27'd0, fl}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
